// File: rtl/polar_pkg.sv
// polar_pkg: shared constants and elaboration-time helpers for the polar encoder
package polar_pkg;
    localparam int MAX_N = 1024;
    localparam logic [255:0] MASK_N256_K128 = {{128{1'b1}}, {128{1'b0}}};
    localparam logic [7:0] MASK_N8_K4 = 8'hE8;

    function automatic int clog2(input int n);
        int r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    function automatic int bit_rev(input int v, input int w);
        int r = 0;
        for (int b = 0; b < w; b++) r = r | (((v >> b) & 1) << (w - 1 - b));
        return r;
    endfunction

    function automatic int popcount(input logic [MAX_N-1:0] m);
        int c = 0;
        for (int i = 0; i < MAX_N; i++) c = c + int'(m[i]);
        return c;
    endfunction

    // Position of the j-th set bit of the mask, scanning upward from bit 0
    function automatic int info_index(input logic [MAX_N-1:0] m, input int j);
        int c = 0;
        int p = 0;
        for (int i = 0; i < MAX_N; i++) begin
            if (m[i]) begin
                if (c == j) p = i;
                c++;
            end
        end
        return p;
    endfunction
endpackage

// File: rtl/polar_butterfly_stage.sv
// polar_butterfly_stage: NUM_STAGES consecutive XOR butterfly spans followed by one enabled register
module polar_butterfly_stage
    import polar_pkg::*;
#(
    parameter int N           = 256,
    parameter int FIRST_STAGE = 0,
    parameter int NUM_STAGES  = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         in_valid,
    input  logic [N-1:0] in_data,
    output logic         out_valid,
    output logic [N-1:0] out_data
);
    for (genvar s = 0; s <= NUM_STAGES; s++) begin : g_lvl
        logic [N-1:0] v;
        if (s == 0) begin : g_in
            assign v = in_data;
        end else begin : g_xor
            for (genvar i = 0; i < N; i++) begin : g_bit
                localparam int D = 1 << (FIRST_STAGE + s - 1);
                assign v[i] = ((i & D) != 0) ? g_lvl[s-1].v[i] : g_lvl[s-1].v[i] ^ g_lvl[s-1].v[i | D];
            end
        end
    end

    // Capture the combined spans whenever the pipeline advances
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (en) begin
            out_valid <= in_valid;
            out_data  <= g_lvl[NUM_STAGES].v;
        end
    end
endmodule

// File: rtl/polar_encode_pipe.sv
// polar_encode_pipe: pipelined polar encoder mapping K info bits to an N-bit codeword
module polar_encode_pipe
    import polar_pkg::*;
#(
    parameter int          N              = 256,
    parameter int          K              = 128,
    parameter logic [N-1:0] INFO_MASK     = N'(MASK_N256_K128),
    parameter int          STAGES_PER_REG = 1,
    parameter bit          BIT_REV        = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [K-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_data,
    output logic         busy
);
    localparam int LOG2N = clog2(N);
    localparam int SPR   = (STAGES_PER_REG < 1) ? 1 : STAGES_PER_REG;
    localparam int NG    = (LOG2N + SPR - 1) / SPR;
    localparam logic [MAX_N-1:0] MASK_X = MAX_N'(INFO_MASK);

    if (N < 8 || N > MAX_N || (N & (N - 1)) != 0) begin : g_err_n
        $error("polar_encode_pipe: N must be a power of 2 in 8..1024");
    end
    if (popcount(MASK_X) != K) begin : g_err_k
        $error("polar_encode_pipe: popcount(INFO_MASK) must equal K");
    end
    if (STAGES_PER_REG < 1 || STAGES_PER_REG > LOG2N) begin : g_err_spr
        $error("polar_encode_pipe: STAGES_PER_REG must be in 1..log2(N)");
    end

    logic         en;
    logic [N-1:0] mixed;
    logic         mix_valid;
    logic [N-1:0] mix_data;
    logic [N-1:0] grp_data [NG+1];
    logic [NG:0]  grp_valid;
    logic [N-1:0] x_out;

    assign en       = out_ready | ~out_valid;
    assign in_ready = en;
    assign busy     = (|grp_valid) | out_valid;

    for (genvar j = 0; j < K; j++) begin : g_info
        localparam int P = info_index(MASK_X, j);
        assign mixed[P] = in_data[j];
    end
    for (genvar i = 0; i < N; i++) begin : g_frozen
        if (!INFO_MASK[i]) begin : g_zero
            assign mixed[i] = 1'b0;
        end
    end

    // Mix stage: info bits scattered onto their non-frozen positions
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mix_valid <= 1'b0;
            mix_data  <= '0;
        end else if (en) begin
            mix_valid <= in_valid;
            mix_data  <= mixed;
        end
    end

    assign grp_valid[0] = mix_valid;
    assign grp_data[0]  = mix_data;

    for (genvar g = 0; g < NG; g++) begin : g_grp
        localparam int F = g * SPR;
        localparam int M = (LOG2N - F < SPR) ? LOG2N - F : SPR;
        polar_butterfly_stage #(.N(N), .FIRST_STAGE(F), .NUM_STAGES(M)) u_stage (
            .clk       (clk),
            .rst_n     (rst_n),
            .en        (en),
            .in_valid  (grp_valid[g]),
            .in_data   (grp_data[g]),
            .out_valid (grp_valid[g+1]),
            .out_data  (grp_data[g+1])
        );
    end

    for (genvar i = 0; i < N; i++) begin : g_rev
        localparam int R = BIT_REV ? bit_rev(i, LOG2N) : i;
        assign x_out[i] = grp_data[NG][R];
    end

    // Output stage: holds the codeword until the downstream takes it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (en) begin
            out_valid <= grp_valid[NG];
            out_data  <= x_out;
        end
    end
endmodule

// File: tb/tb_polar_encode_pipe.sv
// tb_polar_encode_pipe: directed and random checks of the polar encoder against a matrix-form model
module tb_polar_encode_pipe;
    logic clk = 1'b0;
    logic rst_n;
    logic in_valid, in_ready, out_valid, out_ready, busy;
    logic [3:0] in_data;
    logic [7:0] out_data;
    logic in_ready_b, out_valid_b, busy_b;
    logic [7:0] out_data_b;
    logic in_valid_l, in_ready_l, out_valid_l, out_ready_l, busy_l;
    logic [127:0] in_data_l;
    logic [255:0] out_data_l;
    int compared = 0;
    int mismatched = 0;

    localparam logic [255:0] MASK_S = 256'(8'hE8);
    localparam logic [255:0] MASK_L = {{128{1'b1}}, {128{1'b0}}};

    always #5 clk = ~clk;

    polar_encode_pipe #(.N(8), .K(4), .INFO_MASK(8'hE8), .STAGES_PER_REG(1), .BIT_REV(1)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy));

    polar_encode_pipe #(.N(8), .K(4), .INFO_MASK(8'hE8), .STAGES_PER_REG(1), .BIT_REV(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_b), .in_data(in_data),
        .out_valid(out_valid_b), .out_ready(out_ready), .out_data(out_data_b), .busy(busy_b));

    polar_encode_pipe #(.N(256), .K(128), .INFO_MASK(MASK_L), .STAGES_PER_REG(2), .BIT_REV(1)) dut_l (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_l), .in_ready(in_ready_l), .in_data(in_data_l),
        .out_valid(out_valid_l), .out_ready(out_ready_l), .out_data(out_data_l), .busy(busy_l));

    // Codeword straight from the definition: u from the mask, x[a] = XOR of u[b] over b covering a
    function automatic logic [255:0] model(input logic [255:0] info, input logic [255:0] mask,
                                           input int n, input bit rev);
        logic [255:0] u = '0;
        logic [255:0] x = '0;
        logic [255:0] y = '0;
        int j = 0;
        int lg = $clog2(n);
        for (int i = 0; i < n; i++) if (mask[i]) begin u[i] = info[j]; j++; end
        for (int a = 0; a < n; a++)
            for (int b = 0; b < n; b++)
                if ((a & ~b) == 0) x[a] = x[a] ^ u[b];
        for (int i = 0; i < n; i++) begin
            int r = 0;
            for (int t = 0; t < lg; t++) r = r | (((i >> t) & 1) << (lg - 1 - t));
            y[i] = rev ? x[r] : x[i];
        end
        return y;
    endfunction

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard for the N=8 pair
    logic [7:0] q[$];
    logic [7:0] qb[$];
    int acc_cnt = 0, out_cnt = 0, out_seen = 0;
    logic stall_p = 1'b0;
    logic [7:0] held;
    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
            qb.delete();
            stall_p = 1'b0;
        end else begin
            check("busy", 256'(busy), 256'(q.size() != 0));
            check("in_ready", 256'(in_ready), 256'(out_ready || !out_valid));
            check("valid_b", 256'(out_valid_b), 256'(out_valid));
            if (stall_p) check("hold", 256'({out_valid, out_data}), 256'({1'b1, held}));
            if (out_valid) begin
                out_seen++;
                if (q.size() == 0) check("spurious_out", 256'(out_valid), 256'(0));
                else begin
                    check("out_data", 256'(out_data), 256'(q[0]));
                    check("out_data_b", 256'(out_data_b), 256'(qb[0]));
                    if (out_ready) begin
                        void'(q.pop_front());
                        void'(qb.pop_front());
                        out_cnt++;
                    end
                end
            end
            if (in_valid && in_ready) begin
                q.push_back(8'(model(256'(in_data), MASK_S, 8, 1'b1)));
                qb.push_back(8'(model(256'(in_data), MASK_S, 8, 1'b0)));
                acc_cnt++;
            end
            stall_p = out_valid && !out_ready;
            held = out_data;
        end
    end

    // Scoreboard for the N=256 instance
    logic [255:0] ql[$];
    int acc_l = 0, out_l = 0;
    logic stall_l = 1'b0;
    logic [255:0] held_l;
    always @(negedge clk) begin
        if (!rst_n) begin
            ql.delete();
            stall_l = 1'b0;
        end else begin
            check("busy_l", 256'(busy_l), 256'(ql.size() != 0));
            check("in_ready_l", 256'(in_ready_l), 256'(out_ready_l || !out_valid_l));
            if (stall_l) check("hold_l", out_data_l, held_l);
            if (out_valid_l) begin
                if (ql.size() == 0) check("spurious_out_l", 256'(out_valid_l), 256'(0));
                else begin
                    check("out_data_l", out_data_l, ql[0]);
                    if (out_ready_l) begin
                        void'(ql.pop_front());
                        out_l++;
                    end
                end
            end
            if (in_valid_l && in_ready_l) begin
                ql.push_back(model(256'(in_data_l), MASK_L, 256, 1'b1));
                acc_l++;
            end
            stall_l = out_valid_l && !out_ready_l;
            held_l = out_data_l;
        end
    end

    task automatic send_one(input logic [3:0] d, input logic [7:0] e_rev, input logic [7:0] e_dir);
        int n = 1;
        in_valid = 1'b1;
        in_data = d;
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        while (!out_valid && n < 20) begin
            step();
            n++;
        end
        check("latency", 256'(n), 256'(5));
        check("single_rev", 256'(out_data), 256'(e_rev));
        check("single_dir", 256'(out_data_b), 256'(e_dir));
        step();
    endtask

    initial begin
        logic [19:0] pat;
        int base;
        rst_n = 1'b0;
        in_valid = 1'b0;
        in_data = '0;
        out_ready = 1'b1;
        in_valid_l = 1'b0;
        in_data_l = '0;
        out_ready_l = 1'b1;
        #1;
        check("rst_out_valid", 256'(out_valid), 256'(0));
        check("rst_out_data", 256'(out_data), 256'(0));
        check("rst_busy", 256'(busy), 256'(0));
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        step();
        check("in_ready_after_rst", 256'(in_ready), 256'(1));

        check("model_0001_rev", model(256'(4'b0001), MASK_S, 8, 1'b1), 256'(8'h55));
        check("model_0001_dir", model(256'(4'b0001), MASK_S, 8, 1'b0), 256'(8'h0F));
        check("model_1000_rev", model(256'(4'b1000), MASK_S, 8, 1'b1), 256'(8'hFF));
        check("model_0000_rev", model(256'(4'b0000), MASK_S, 8, 1'b1), 256'(8'h00));

        send_one(4'b0001, 8'h55, 8'h0F);
        send_one(4'b1000, 8'hFF, 8'hFF);
        send_one(4'b0000, 8'h00, 8'h00);

        pat = '0;
        for (int i = 0; i < 20; i++) begin
            in_valid = (i < 8);
            in_data = 4'(i * 5 + 1);
            step();
            pat[i] = out_valid;
        end
        check("b2b_pattern", 256'(pat), 256'(20'h00FF0));

        base = acc_cnt;
        for (int i = 0; i < 30; i++) begin
            out_ready = !(i >= 8 && i < 12);
            in_valid = (acc_cnt - base) < 10;
            in_data = 4'(i + 7);
            #1;
            if (out_valid && !out_ready) check("bp_in_ready", 256'(in_ready), 256'(0));
            step();
        end
        check("bp_count", 256'(acc_cnt - base), 256'(10));

        for (int i = 0; i < 200; i++) begin
            in_valid = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 1));
            in_data = 4'($urandom);
            step();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (15) step();
        check("drain_count", 256'(out_cnt), 256'(acc_cnt));
        check("drain_queue", 256'(q.size()), 256'(0));

        for (int i = 0; i < 400; i++) begin
            in_valid_l = 1'($urandom_range(0, 1));
            out_ready_l = 1'($urandom_range(0, 1));
            in_data_l = {$urandom, $urandom, $urandom, $urandom};
            step();
        end
        in_valid_l = 1'b0;
        out_ready_l = 1'b1;
        repeat (20) step();
        check("drain_count_l", 256'(out_l), 256'(acc_l));
        check("drain_queue_l", 256'(ql.size()), 256'(0));

        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data = 4'(i + 9);
            step();
        end
        in_valid = 1'b0;
        check("busy_pre_rst", 256'(busy), 256'(1));
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", 256'(out_valid), 256'(0));
        check("mid_rst_out_data", 256'(out_data), 256'(0));
        check("mid_rst_busy", 256'(busy), 256'(0));
        repeat (2) step();
        rst_n = 1'b1;
        base = out_seen;
        repeat (12) step();
        check("no_out_after_rst", 256'(out_seen - base), 256'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
